mlp_layer_scheduler: RTL

MLP_LAYER_SCHEDULER -- requirements
Module: mlp_layer_scheduler

---
 rtl/mlp_layer_scheduler_if.sv | 35 +++
 rtl/mlp_layer_scheduler.sv | 119 +++++++++++
 2 files changed

// File: rtl/mlp_layer_scheduler_if.sv
// Control bus between the MLP layer scheduler (master) and the neuron
// datapath / host side (slave).
interface mlp_layer_scheduler_if #(
  parameter int M = 2,
  parameter int N = 2
);
  localparam int LW = (M > 2) ? $clog2(M - 1) : 1;
  localparam int NW = $clog2(N);

  logic          start;
  logic          abort;
  logic          neu_done;
  logic          load_x;
  logic          read_en;
  logic          neu_start;
  logic          write_en;
  logic          swap;
  logic [LW-1:0] layer_addr;
  logic [NW-1:0] neuron_addr;
  logic          busy;
  logic          done;
  logic          error;

  modport master (
    input  start, abort, neu_done,
    output load_x, read_en, neu_start, write_en, swap,
           layer_addr, neuron_addr, busy, done, error
  );

  modport slave (
    output start, abort, neu_done,
    input  load_x, read_en, neu_start, write_en, swap,
           layer_addr, neuron_addr, busy, done, error
  );
endinterface

// File: rtl/mlp_layer_scheduler.sv
// Sequences one full MLP forward pass: per layer, per neuron it reads weights,
// launches the neuron datapath, waits (with watchdog) and writes the result.
module mlp_layer_scheduler #(
  parameter int M   = 2,
  parameter int N   = 2,
  parameter int TMO = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  mlp_layer_scheduler_if.master bus
);
  localparam int LW = (M > 2) ? $clog2(M - 1) : 1;
  localparam int NW = $clog2(N);
  localparam int WW = (TMO > 1) ? $clog2(TMO) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, READ, LAUNCH, WAIT, WRITE, NEXT, FIN} state_t;

  state_t        state_reg, state_next;
  logic [LW-1:0] layer_reg;
  logic [NW-1:0] neuron_reg;
  logic [WW-1:0] wd_reg;
  logic          load_x_reg, read_en_reg, neu_start_reg, write_en_reg;
  logic          swap_reg, busy_reg, done_reg, error_reg;
  logic          timeout, last_neuron, last_layer, accept;

  assign last_neuron = (neuron_reg == NW'(N - 1));
  assign last_layer  = (layer_reg == LW'(M - 2));
  assign accept      = (state_reg == IDLE) && bus.start;

  always_comb begin
    state_next = state_reg;
    timeout    = 1'b0;
    case (state_reg)
      IDLE:    if (bus.start) state_next = LOAD;
      LOAD:    state_next = READ;
      READ:    state_next = LAUNCH;
      LAUNCH:  state_next = WAIT;
      WAIT: begin
        // A result arriving on the final watchdog cycle still counts.
        if (bus.neu_done) begin
          state_next = WRITE;
        end else if (wd_reg == WW'(TMO - 1)) begin
          state_next = IDLE;
          timeout    = 1'b1;
        end
      end
      WRITE:   state_next = NEXT;
      NEXT:    state_next = (last_neuron && last_layer) ? FIN : READ;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.abort && (state_reg != IDLE)) begin
      state_next = IDLE;
      timeout    = 1'b0;
    end
  end

  // Pulses are registered from the next state so each is a clean flop output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      layer_reg     <= '0;
      neuron_reg    <= '0;
      wd_reg        <= '0;
      load_x_reg    <= 1'b0;
      read_en_reg   <= 1'b0;
      neu_start_reg <= 1'b0;
      write_en_reg  <= 1'b0;
      swap_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      load_x_reg    <= (state_next == LOAD);
      read_en_reg   <= (state_next == READ);
      neu_start_reg <= (state_next == LAUNCH);
      write_en_reg  <= (state_next == WRITE);
      done_reg      <= (state_next == FIN);
      busy_reg      <= (state_next != IDLE);
      swap_reg      <= (state_next == NEXT) && last_neuron && !last_layer;

      if (accept) begin
        layer_reg  <= '0;
        neuron_reg <= '0;
      end else if ((state_reg == NEXT) && (state_next == READ)) begin
        if (last_neuron) begin
          neuron_reg <= '0;
          layer_reg  <= layer_reg + LW'(1);
        end else begin
          neuron_reg <= neuron_reg + NW'(1);
        end
      end

      if (state_reg == LAUNCH) begin
        wd_reg <= '0;
      end else if ((state_reg == WAIT) && (wd_reg != WW'(TMO - 1))) begin
        wd_reg <= wd_reg + WW'(1);
      end

      if (accept) begin
        error_reg <= 1'b0;
      end else if (timeout) begin
        error_reg <= 1'b1;
      end
    end
  end

  assign bus.load_x      = load_x_reg;
  assign bus.read_en     = read_en_reg;
  assign bus.neu_start   = neu_start_reg;
  assign bus.write_en    = write_en_reg;
  assign bus.swap        = swap_reg;
  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.error       = error_reg;
  assign bus.layer_addr  = layer_reg;
  assign bus.neuron_addr = neuron_reg;
endmodule
